fetch_unit: RTL and testbench



---
 rtl/fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : instruction fetch stage with prefetch queue and redirect flush
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h8000_0000,
  parameter int          DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [31:0]   C_ALIGN = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   pc_d  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   ins_d [DEPTH];

  logic          pop;
  logic          ack;
  logic          push;
  logic [31:0]   target;
  logic [CW-1:0] occ_after_pop;

  always_comb begin
    pop           = (count_q != '0) && instr_ready;
    ack           = mem_req_q && mem_ack;
    target        = redirect_pc & C_ALIGN;
    occ_after_pop = count_q - CW'(pop);
    push          = 1'b0;
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    ins_d         = ins_q;

    case (state_q)
      IDLE: begin
        if (occ_after_pop < C_DEPTH) begin
          state_d    = REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (ack) begin
          push       = 1'b1;
          fetch_pc_d = mem_addr_q + 32'd4;
          // A new request is only issued if its slot is guaranteed free.
          if ((occ_after_pop + CW'(1)) < C_DEPTH) begin
            mem_addr_d = mem_addr_q + 32'd4;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (ack) begin
          state_d    = REQ;
          mem_addr_d = fetch_pc_q;
        end
      end
      default: state_d = IDLE;
    endcase

    count_d = occ_after_pop + CW'(push);
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    if (push) begin
      pc_d[tail_q]  = mem_addr_q;
      ins_d[tail_q] = mem_rdata;
    end

    // Redirect overrides everything above: flush, retarget, and park a
    // still-outstanding stale request in DROP until memory answers it.
    if (redirect) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      fetch_pc_d = target;
      mem_addr_d = mem_addr_q;
      case (state_q)
        IDLE: begin
          state_d    = REQ;
          mem_addr_d = target;
        end
        REQ, DROP: begin
          if (ack) begin
            state_d    = REQ;
            mem_addr_d = target;
          end else begin
            state_d = DROP;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= PC_INIT & C_ALIGN;
      fetch_pc_q <= PC_INIT & C_ALIGN;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    ins_q <= ins_d;
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = (count_q != '0);
  assign instr       = ins_q[head_q];
  assign instr_pc    = pc_q[head_q];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed and randomized self-checking bench for fetch_unit
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h8000_0000;
  localparam int          DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        use_bad;

  int          n_assert = 0;
  int          n_fail   = 0;

  fetch_unit #(.PC_INIT(PC_INIT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  always_comb mem_rdata = use_bad ? 32'hDEAD_BEEF : word_at(mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_pc;
  logic [31:0] pend_addr;
  logic        pend;
  logic        redir_prev;
  int          pops;
  logic [31:0] wrap_pc [3];

  initial begin
    rst = 1'b1; mem_ack = 1'b1; instr_ready = 1'b1; redirect = 1'b0;
    redirect_pc = '0; use_bad = 1'b0;

    // Reset state and zero-wait streaming
    repeat (3) tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, PC_INIT);
    chk("rst_valid", instr_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, PC_INIT);
    chk("first_valid", instr_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stream_valid", instr_valid, 1'b1);
      chk("stream_pc", instr_pc, PC_INIT + 32'(4 * k));
      chk("stream_instr", instr, word_at(PC_INIT + 32'(4 * k)));
      chk("stream_addr", mem_addr, PC_INIT + 32'(4 * k + 4));
    end

    // Backpressure fills the queue, then drains in order
    rst = 1'b1; tick(); rst = 1'b0; instr_ready = 1'b0;
    tick();
    repeat (6) tick();
    chk("full_req", mem_req, 1'b0);
    chk("full_valid", instr_valid, 1'b1);
    chk("full_head", instr_pc, PC_INIT);
    instr_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("drain_pc", instr_pc, PC_INIT + 32'(4 * k));
      chk("drain_instr", instr, word_at(PC_INIT + 32'(4 * k)));
      chk("drain_addr", mem_addr, PC_INIT + 32'(4 * k + 4));
    end

    // Redirect while a request is pending: stale data must be dropped
    mem_ack = 1'b0;
    tick();
    chk("pend_addr", mem_addr, 32'h8000_0010);
    chk("pend_valid", instr_valid, 1'b0);
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect = 1'b0;
    chk("drop_addr", mem_addr, 32'h8000_0010);
    chk("drop_valid", instr_valid, 1'b0);
    repeat (2) begin
      tick();
      chk("drop_hold_req", mem_req, 1'b1);
      chk("drop_hold_addr", mem_addr, 32'h8000_0010);
    end
    mem_ack = 1'b1; use_bad = 1'b1;
    tick();
    use_bad = 1'b0;
    chk("drop_target", mem_addr, 32'h8000_0100);
    chk("drop_discard", instr_valid, 1'b0);
    tick();
    chk("tgt_valid", instr_valid, 1'b1);
    chk("tgt_pc", instr_pc, 32'h8000_0100);
    chk("tgt_instr", instr, word_at(32'h8000_0100));

    // Redirect coinciding with ack and a pop
    redirect = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    redirect = 1'b0;
    chk("flush_valid", instr_valid, 1'b0);
    chk("flush_addr", mem_addr, 32'h8000_0200);
    tick();
    chk("flush_pc", instr_pc, 32'h8000_0200);
    chk("flush_valid2", instr_valid, 1'b1);

    // Misaligned target near the top of the address space wraps to zero
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFB;
    tick();
    redirect = 1'b0;
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC; wrap_pc[2] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wrap_pc", instr_pc, wrap_pc[k]);
      chk("wrap_addr", mem_addr, wrap_pc[k] + 32'd4);
    end

    // Reset in the middle of a request with one entry queued
    rst = 1'b1;
    tick();
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_valid", instr_valid, 1'b0);
    chk("mrst_addr", mem_addr, PC_INIT);
    rst = 1'b0;
    tick();
    chk("mrst_restart", mem_addr, PC_INIT);
    tick();
    chk("mrst_pc", instr_pc, PC_INIT);

    // Randomized traffic against a sequential-PC reference
    rst = 1'b1; tick(); rst = 1'b0;
    exp_pc = PC_INIT; pend = 1'b0; redir_prev = 1'b0; pops = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rand_align", {30'd0, mem_addr[1:0]}, 32'd0);
      if (pend) begin
        chk("rand_req_hold", mem_req, 1'b1);
        chk("rand_addr_hold", mem_addr, pend_addr);
      end
      if (redir_prev) chk("rand_flush", instr_valid, 1'b0);
      if (instr_valid) begin
        chk("rand_pc", instr_pc, exp_pc);
        chk("rand_instr", instr, word_at(exp_pc));
      end
      mem_ack     = ($urandom_range(0, 9) < 6);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom());
      pend       = mem_req && !mem_ack;
      pend_addr  = mem_addr;
      redir_prev = redirect;
      if (redirect) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick();
    end
    redirect = 1'b0;
    chk("rand_progress", 32'(pops > 300), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
